// File: rtl/pbb_pkg.sv
// Shared types and constants for the peripheral bus bridge.
// Optional macro PBB_TIMEOUT_EN is consumed by periph_bus_bridge (see that file).
package pbb_pkg;

  typedef enum logic [1:0] {IDLE, RAM, PWAIT, RESP} state_e;

  typedef enum logic [1:0] {REG_RAM, REG_PER, REG_UNMAPPED} region_e;

  // Peripheral index is carried at full 1..16 channel width regardless of N_PERIPH.
  localparam int IDX_W  = 4;
  localparam int MAX_CH = 1 << IDX_W;

  // Read data returned on a peripheral timeout; sliced to DATA_W (DATA_W <= 256).
  localparam logic [255:0] READ_ERR_VALUE = '1;

endpackage

// File: rtl/periph_bus_bridge_if.sv
// CPU load/store port of the bridge: the CPU is the master, the bridge the slave.
interface periph_bus_bridge_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              err;
  logic              busy;

  modport master (output req, we, addr, wdata, input rdata, ready, err, busy);
  modport slave  (input req, we, addr, wdata, output rdata, ready, err, busy);

endinterface

// File: rtl/pbb_addr_decode.sv
// Combinational word-address decoder: RAM below 2**RAM_AW, then N_PERIPH windows
// of 2**SPAN_LOG2 words each, everything above is unmapped.
module pbb_addr_decode
  import pbb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int RAM_AW    = 8,
  parameter int N_PERIPH  = 4,
  parameter int SPAN_LOG2 = 4
) (
  input  logic [ADDR_W-1:0]    addr_i,
  output region_e              region_o,
  output logic [IDX_W-1:0]     idx_o,
  output logic [SPAN_LOG2-1:0] offset_o
);

  localparam logic [ADDR_W-1:0] RAM_SIZE = {{(ADDR_W-1){1'b0}}, 1'b1} << RAM_AW;

  logic [ADDR_W-1:0] win_idx;

  // Only meaningful when addr_i >= RAM_SIZE, so the subtraction cannot wrap there.
  assign win_idx = (addr_i - RAM_SIZE) >> SPAN_LOG2;

  always_comb begin
    region_o = REG_UNMAPPED;
    idx_o    = '0;
    offset_o = addr_i[SPAN_LOG2-1:0];
    if (addr_i < RAM_SIZE) begin
      region_o = REG_RAM;
    end else if (win_idx < ADDR_W'(N_PERIPH)) begin
      region_o = REG_PER;
      idx_o    = win_idx[IDX_W-1:0];
    end
  end

endmodule

// File: rtl/periph_bus_bridge.sv
// CPU-to-RAM/peripheral bridge: fixed two-cycle RAM access, ack-based peripheral access.
// Define PBB_TIMEOUT_EN to bound the peripheral wait to TIMEOUT cycles.
module periph_bus_bridge
  import pbb_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 32,
  parameter int RAM_AW    = 8,
  parameter int N_PERIPH  = 4,
  parameter int SPAN_LOG2 = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  periph_bus_bridge_if.slave         cpu,
  output logic                       ram_we_o,
  output logic [RAM_AW-1:0]          ram_addr_o,
  output logic [DATA_W-1:0]          ram_wdata_o,
  input  logic [DATA_W-1:0]          ram_rdata_i,
  output logic [N_PERIPH-1:0]        p_sel_o,
  output logic                       p_we_o,
  output logic [SPAN_LOG2-1:0]       p_addr_o,
  output logic [DATA_W-1:0]          p_wdata_o,
  input  logic [N_PERIPH*DATA_W-1:0] p_rdata_i,
  input  logic [N_PERIPH-1:0]        p_ack_i
);

  state_e                state_q, state_d;
  region_e               region_q, region_d;
  logic                  we_q, we_d;
  logic [RAM_AW-1:0]     addr_q, addr_d;
  logic [SPAN_LOG2-1:0]  off_q, off_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;

  region_e               dec_region;
  logic [IDX_W-1:0]      dec_idx;
  logic [SPAN_LOG2-1:0]  dec_off;
  logic [N_PERIPH-1:0]   sel_vec;
  logic                  ack_hit;
  logic [DATA_W-1:0]     p_rdata_arr [MAX_CH];

  pbb_addr_decode #(
    .ADDR_W    (ADDR_W),
    .RAM_AW    (RAM_AW),
    .N_PERIPH  (N_PERIPH),
    .SPAN_LOG2 (SPAN_LOG2)
  ) u_decode (
    .addr_i   (cpu.addr),
    .region_o (dec_region),
    .idx_o    (dec_idx),
    .offset_o (dec_off)
  );

  for (genvar gi = 0; gi < MAX_CH; gi++) begin : g_ch
    if (gi < N_PERIPH) begin : g_used
      assign sel_vec[gi]     = (idx_q == IDX_W'(gi));
      assign p_rdata_arr[gi] = p_rdata_i[gi*DATA_W +: DATA_W];
    end else begin : g_unused
      assign p_rdata_arr[gi] = '0;
    end
  end

  // Selects and strobes come straight off the state register so reset kills them at once.
  assign p_sel_o = (state_q == PWAIT) ? sel_vec : '0;
  assign ack_hit = |(p_ack_i & p_sel_o);

`ifdef PBB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired;

  assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign cnt_d   = (state_q == PWAIT) ? cnt_q + 1'b1 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic expired;
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    region_d    = region_q;
    we_d        = we_q;
    addr_d      = addr_q;
    off_d       = off_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    p_we_o      = 1'b0;
    p_addr_o    = '0;
    p_wdata_o   = '0;
    cpu.ready   = 1'b0;
    cpu.err     = 1'b0;
    cpu.rdata   = '0;
    cpu.busy    = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (cpu.req) begin
          we_d     = cpu.we;
          addr_d   = cpu.addr[RAM_AW-1:0];
          off_d    = dec_off;
          idx_d    = dec_idx;
          wdata_d  = cpu.wdata;
          region_d = dec_region;
          rdata_d  = '0;
          err_d    = 1'b0;
          case (dec_region)
            REG_RAM: state_d = RAM;
            REG_PER: state_d = PWAIT;
            default: begin
              err_d   = 1'b1;
              state_d = RESP;
            end
          endcase
        end
      end
      RAM: begin
        ram_we_o    = we_q;
        ram_addr_o  = addr_q;
        ram_wdata_o = wdata_q;
        state_d     = RESP;
      end
      PWAIT: begin
        p_we_o    = we_q;
        p_addr_o  = off_q;
        p_wdata_o = wdata_q;
        // A same-cycle ack beats an expiring timeout.
        if (ack_hit) begin
          rdata_d = we_q ? '0 : p_rdata_arr[idx_q];
          state_d = RESP;
        end else if (expired) begin
          rdata_d = READ_ERR_VALUE[DATA_W-1:0];
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        cpu.ready = 1'b1;
        cpu.err   = err_q;
        // RAM read data arrives one cycle after the address, i.e. exactly now.
        cpu.rdata = (region_q == REG_RAM && !we_q) ? ram_rdata_i : rdata_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      region_q <= REG_RAM;
      we_q     <= 1'b0;
      addr_q   <= '0;
      off_q    <= '0;
      idx_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      off_q    <= off_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_periph_bus_bridge.sv
// Self-checking bench for periph_bus_bridge: directed scenarios plus randomized traffic
// against a region/latency reference model. Honours PBB_TIMEOUT_EN like the design.
module tb_periph_bus_bridge;

  localparam int DATA_W    = 64;
  localparam int ADDR_W    = 32;
  localparam int RAM_AW    = 8;
  localparam int N_PERIPH  = 4;
  localparam int SPAN_LOG2 = 4;
  localparam int TIMEOUT   = 15;
  localparam int RAM_WORDS = 1 << RAM_AW;
  localparam int WIN_WORDS = 1 << SPAN_LOG2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  periph_bus_bridge_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) cpu ();

  logic                       ram_we;
  logic [RAM_AW-1:0]          ram_addr;
  logic [DATA_W-1:0]          ram_wdata;
  logic [DATA_W-1:0]          ram_rdata;
  logic [N_PERIPH-1:0]        p_sel;
  logic                       p_we;
  logic [SPAN_LOG2-1:0]       p_addr;
  logic [DATA_W-1:0]          p_wdata;
  logic [N_PERIPH*DATA_W-1:0] p_rdata;
  logic [N_PERIPH-1:0]        p_ack;

  periph_bus_bridge #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RAM_AW(RAM_AW),
    .N_PERIPH(N_PERIPH), .SPAN_LOG2(SPAN_LOG2), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cpu(cpu),
    .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
    .p_sel_o(p_sel), .p_we_o(p_we), .p_addr_o(p_addr), .p_wdata_o(p_wdata),
    .p_rdata_i(p_rdata), .p_ack_i(p_ack)
  );

  // Environment RAM with one-cycle registered read.
  logic [DATA_W-1:0] ram_mem [RAM_WORDS];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  // Reference model state: what the CPU should read back from RAM.
  logic [DATA_W-1:0] exp_mem [RAM_WORDS];
  bit                written [RAM_WORDS];

  int errors = 0;
  int checks = 0;

  // Expected result of one access, from the address map and handshake rules.
  task automatic model(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                       input int ack_dly, input logic [DATA_W-1:0] pdata,
                       output logic [DATA_W-1:0] erd, output logic eerr, output int elat);
    if (addr < RAM_WORDS) begin
      elat = 2;
      eerr = 1'b0;
      erd  = '0;
      if (we) begin
        exp_mem[addr[RAM_AW-1:0]] = wdata;
        written[addr[RAM_AW-1:0]] = 1'b1;
      end else begin
        erd = exp_mem[addr[RAM_AW-1:0]];
      end
    end else if (addr < RAM_WORDS + N_PERIPH * WIN_WORDS) begin
      elat = ack_dly + 2;
      eerr = 1'b0;
      erd  = we ? '0 : pdata;
`ifdef PBB_TIMEOUT_EN
      if (ack_dly >= TIMEOUT) begin
        elat = TIMEOUT + 1;
        eerr = 1'b1;
        erd  = '1;
      end
`endif
    end else begin
      elat = 1;
      eerr = 1'b1;
      erd  = '0;
    end
  endtask

  // Drives one access starting in IDLE (at a negedge) and watches strobes every cycle.
  // ack_dly = number of PWAIT cycles before the one carrying the ack.
  task automatic run_txn(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                         input int ack_dly, input logic [DATA_W-1:0] pdata, input int wrong_ch,
                         output logic [DATA_W-1:0] rd, output logic er, output int lat);
    int region;
    int idx;
    logic [N_PERIPH-1:0] exp_sel;
    logic exp_we;
    bit done;
    region  = (addr < RAM_WORDS) ? 0 : ((addr < RAM_WORDS + N_PERIPH * WIN_WORDS) ? 1 : 2);
    idx     = (region == 1) ? int'((addr - RAM_WORDS) / WIN_WORDS) : 0;
    exp_sel = (region == 1) ? N_PERIPH'(1 << idx) : '0;
    rd = '0; er = 1'b0; lat = -1; done = 1'b0;
    cpu.req = 1'b1; cpu.we = we; cpu.addr = addr; cpu.wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    cpu.req = 1'b0;
    for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
      if (cpu.ready === 1'b1) begin
        rd = cpu.rdata; er = cpu.err; lat = cyc; done = 1'b1;
        checks++;
        if (p_sel !== '0 || ram_we !== 1'b0) begin
          errors++;
          $display("FAIL resp_strobes: p_sel=%b ram_we=%b, expected 0/0", p_sel, ram_we);
        end
      end else begin
        exp_we = (region == 0 && cyc == 1) ? we : 1'b0;
        checks++;
        if (ram_we !== exp_we || cpu.busy !== 1'b1) begin
          errors++;
          $display("FAIL ram_strobe: cyc=%0d ram_we=%b busy=%b, expected %b/1", cyc, ram_we, cpu.busy, exp_we);
        end
        if (region == 0 && cyc == 1) begin
          checks++;
          if (ram_addr !== addr[RAM_AW-1:0] || (we && ram_wdata !== wdata)) begin
            errors++;
            $display("FAIL ram_bus: ram_addr=%h ram_wdata=%h, expected %h/%h", ram_addr, ram_wdata, addr[RAM_AW-1:0], wdata);
          end
        end
        checks++;
        if (p_sel !== exp_sel || (region == 1 && (p_addr !== addr[SPAN_LOG2-1:0] || p_we !== we || p_wdata !== wdata))) begin
          errors++;
          $display("FAIL periph_bus: cyc=%0d p_sel=%b p_addr=%h p_we=%b, expected %b/%h/%b", cyc, p_sel, p_addr, p_we, exp_sel, addr[SPAN_LOG2-1:0], we);
        end
        p_ack = '0;
        if (region == 1 && wrong_ch >= 0 && wrong_ch != idx) begin
          p_ack[wrong_ch] = 1'b1;
          p_rdata[wrong_ch*DATA_W +: DATA_W] = ~pdata;
        end
        if (region == 1 && cyc - 1 == ack_dly) begin
          p_ack[idx] = 1'b1;
          p_rdata[idx*DATA_W +: DATA_W] = pdata;
        end
        @(negedge clk);
      end
    end
    p_ack = '0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: no cpu_ready within 200 cycles for addr=%h", addr);
    end
    @(negedge clk);
    checks++;
    if (cpu.busy !== 1'b0 || cpu.ready !== 1'b0) begin
      errors++;
      $display("FAIL back_to_idle: busy=%b ready=%b, expected 0/0", cpu.busy, cpu.ready);
    end
    $display("txn we=%0b addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d", we, addr, wdata, rd, er, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (cpu.busy !== 1'b0 || cpu.ready !== 1'b0 || cpu.err !== 1'b0 || cpu.rdata !== '0) begin
      errors++;
      $display("FAIL reset_cpu: busy=%b ready=%b err=%b rdata=%h, expected all 0", cpu.busy, cpu.ready, cpu.err, cpu.rdata);
    end
    checks++;
    if (ram_we !== 1'b0 || p_sel !== '0 || p_we !== 1'b0 || ram_addr !== '0 || p_wdata !== '0) begin
      errors++;
      $display("FAIL reset_strobes: ram_we=%b p_sel=%b p_we=%b, expected all 0", ram_we, p_sel, p_we);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ram_rw();
    logic [DATA_W-1:0] rd, erd;
    logic er, eer;
    int lat, elat;
    model(1'b1, 32'h05, 64'hAB, 0, '0, erd, eer, elat);
    run_txn(1'b1, 32'h05, 64'hAB, 0, '0, -1, rd, er, lat);
    checks++;
    if (rd !== erd || er !== eer || lat !== elat) begin
      errors++;
      $display("FAIL ram_write: rdata=%h err=%b lat=%0d, expected %h/%b/%0d", rd, er, lat, erd, eer, elat);
    end
    model(1'b0, 32'h05, '0, 0, '0, erd, eer, elat);
    run_txn(1'b0, 32'h05, '0, 0, '0, -1, rd, er, lat);
    checks++;
    if (rd !== erd || er !== eer || lat !== elat) begin
      errors++;
      $display("FAIL ram_read: rdata=%h err=%b lat=%0d, expected %h/%b/%0d", rd, er, lat, erd, eer, elat);
    end
  endtask

  task automatic test_periph_read();
    logic [DATA_W-1:0] rd, erd;
    logic er, eer;
    int lat, elat;
    model(1'b0, 32'h110, '0, 3, 64'h1234, erd, eer, elat);
    run_txn(1'b0, 32'h110, '0, 3, 64'h1234, -1, rd, er, lat);
    checks++;
    if (rd !== erd || er !== eer || lat !== elat) begin
      errors++;
      $display("FAIL periph_read: rdata=%h err=%b lat=%0d, expected %h/%b/%0d", rd, er, lat, erd, eer, elat);
    end
    model(1'b0, 32'h100, '0, 0, 64'hCAFE, erd, eer, elat);
    run_txn(1'b0, 32'h100, '0, 0, 64'hCAFE, -1, rd, er, lat);
    checks++;
    if (rd !== erd || er !== eer || lat !== elat) begin
      errors++;
      $display("FAIL periph_immediate_ack: rdata=%h err=%b lat=%0d, expected %h/%b/%0d", rd, er, lat, erd, eer, elat);
    end
  endtask

  task automatic test_unmapped();
    logic [DATA_W-1:0] rd, erd;
    logic er, eer;
    int lat, elat;
    model(1'b0, 32'h140, '0, 0, '0, erd, eer, elat);
    run_txn(1'b0, 32'h140, '0, 0, '0, -1, rd, er, lat);
    checks++;
    if (rd !== erd || er !== eer || lat !== elat) begin
      errors++;
      $display("FAIL unmapped: rdata=%h err=%b lat=%0d, expected %h/%b/%0d", rd, er, lat, erd, eer, elat);
    end
  endtask

  task automatic test_wrong_ack();
    logic [DATA_W-1:0] rd, erd;
    logic er, eer;
    int lat, elat;
    model(1'b0, 32'h115, '0, 4, 64'h5A5A, erd, eer, elat);
    run_txn(1'b0, 32'h115, '0, 4, 64'h5A5A, 2, rd, er, lat);
    checks++;
    if (rd !== erd || er !== eer || lat !== elat) begin
      errors++;
      $display("FAIL wrong_channel_ack: rdata=%h err=%b lat=%0d, expected %h/%b/%0d", rd, er, lat, erd, eer, elat);
    end
  endtask

  task automatic test_timeout();
`ifdef PBB_TIMEOUT_EN
    logic [DATA_W-1:0] rd, erd;
    logic er, eer;
    int lat, elat;
    model(1'b0, 32'h130, '0, 1000, 64'h77, erd, eer, elat);
    run_txn(1'b0, 32'h130, '0, 1000, 64'h77, -1, rd, er, lat);
    checks++;
    if (rd !== erd || er !== eer || lat !== elat) begin
      errors++;
      $display("FAIL timeout_expire: rdata=%h err=%b lat=%0d, expected %h/%b/%0d", rd, er, lat, erd, eer, elat);
    end
    model(1'b0, 32'h130, '0, TIMEOUT - 1, 64'h88, erd, eer, elat);
    run_txn(1'b0, 32'h130, '0, TIMEOUT - 1, 64'h88, -1, rd, er, lat);
    checks++;
    if (rd !== erd || er !== eer || lat !== elat) begin
      errors++;
      $display("FAIL timeout_ack_wins: rdata=%h err=%b lat=%0d, expected %h/%b/%0d", rd, er, lat, erd, eer, elat);
    end
`else
    int bad;
    bad = 0;
    cpu.req = 1'b1; cpu.we = 1'b0; cpu.addr = 32'h130; cpu.wdata = '0;
    @(posedge clk);
    @(negedge clk);
    cpu.req = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (cpu.busy !== 1'b1 || cpu.ready !== 1'b0 || p_sel !== 4'b1000) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL wait_forever: %0d cycles left PWAIT early, expected 0", bad);
    end
    p_ack[3] = 1'b1;
    p_rdata[3*DATA_W +: DATA_W] = 64'h99;
    @(negedge clk);
    p_ack = '0;
    checks++;
    if (cpu.ready !== 1'b1 || cpu.err !== 1'b0 || cpu.rdata !== 64'h99) begin
      errors++;
      $display("FAIL late_ack: ready=%b err=%b rdata=%h, expected 1/0/99", cpu.ready, cpu.err, cpu.rdata);
    end
    $display("txn we=0 addr=130 held 60 cycles -> rdata=%h err=%0b", cpu.rdata, cpu.err);
    @(negedge clk);
`endif
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] rd, erd;
    logic er, eer;
    int lat, elat;
    int stray;
    stray = 0;
    cpu.req = 1'b1; cpu.we = 1'b0; cpu.addr = 32'h120; cpu.wdata = '0;
    @(posedge clk);
    @(negedge clk);
    cpu.req = 1'b0;
    @(negedge clk);
    checks++;
    if (p_sel !== 4'b0100) begin
      errors++;
      $display("FAIL pre_reset_sel: p_sel=%b, expected 0100", p_sel);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (p_sel !== '0 || cpu.busy !== 1'b0 || ram_we !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: p_sel=%b busy=%b ram_we=%b, expected 0/0/0", p_sel, cpu.busy, ram_we);
    end
    p_ack = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (cpu.ready !== 1'b0) stray++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (cpu.ready !== 1'b0) stray++;
    p_ack = '0;
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL reset_no_ready: %0d ready pulses, expected 0", stray);
    end
    model(1'b0, 32'h05, '0, 0, '0, erd, eer, elat);
    run_txn(1'b0, 32'h05, '0, 0, '0, -1, rd, er, lat);
    checks++;
    if (rd !== erd || er !== eer || lat !== elat) begin
      errors++;
      $display("FAIL after_reset: rdata=%h err=%b lat=%0d, expected %h/%b/%0d", rd, er, lat, erd, eer, elat);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_rdy;
    cpu.req = 1'b1; cpu.we = 1'b0; cpu.addr = 32'h05; cpu.wdata = '0;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      exp_rdy = (cyc % 3 == 2);
      checks++;
      if (cpu.ready !== exp_rdy || (exp_rdy && cpu.rdata !== exp_mem[5])) begin
        errors++;
        $display("FAIL back_to_back: cyc=%0d ready=%b rdata=%h, expected %b/%h", cyc, cpu.ready, cpu.rdata, exp_rdy, exp_mem[5]);
      end
      if (exp_rdy) $display("txn we=0 addr=005 held req -> ready at cycle %0d rdata=%h", cyc, cpu.rdata);
    end
    cpu.req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] rd, erd, wd, pd;
    logic er, eer, we;
    logic [ADDR_W-1:0] addr;
    int lat, elat, dly, wch;
    for (int n = 0; n < 40; n++) begin
      we  = 1'($urandom_range(0, 1));
      wd  = {$urandom, $urandom};
      pd  = {$urandom, $urandom};
      dly = $urandom_range(0, 6);
      wch = $urandom_range(0, 4) - 1;
      case ($urandom_range(0, 3))
        0, 1: addr = $urandom_range(0, RAM_WORDS - 1);
        2: addr = $urandom_range(RAM_WORDS, RAM_WORDS + N_PERIPH * WIN_WORDS - 1);
        default: addr = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(RAM_WORDS + N_PERIPH * WIN_WORDS, 1024);
      endcase
      if (addr < RAM_WORDS && !we && !written[addr[RAM_AW-1:0]]) we = 1'b1;
      model(we, addr, wd, dly, pd, erd, eer, elat);
      run_txn(we, addr, wd, dly, pd, wch, rd, er, lat);
      checks++;
      if (rd !== erd || er !== eer || lat !== elat) begin
        errors++;
        $display("FAIL random_%0d: addr=%h rdata=%h err=%b lat=%0d, expected %h/%b/%0d", n, addr, rd, er, lat, erd, eer, elat);
      end
    end
  endtask

  initial begin
    cpu.req = 1'b0; cpu.we = 1'b0; cpu.addr = '0; cpu.wdata = '0;
    p_ack = '0; p_rdata = '0;
    for (int i = 0; i < RAM_WORDS; i++) begin
      exp_mem[i] = '0;
      written[i] = 1'b0;
    end
    @(negedge clk);
    test_reset();
    test_ram_rw();
    test_periph_read();
    test_unmapped();
    test_wrong_ack();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
